// File: rtl/adc_seq_multich_pkg.sv
// ---------------------------------------------------------------------------
// adc_seq_pkg
// Shared definitions for the multi-channel ADC scan sequencer:
//   - FSM state encodings (fixed-width constants for legacy compatibility)
//   - command-frame layout constant
//   - channel-pick struct and priority functions used to walk the enable mask
// ---------------------------------------------------------------------------
package adc_seq_pkg;

    localparam int MAX_CH   = 16;   // widest mask the pick functions handle
    localparam int MAX_CH_W = 4;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_SEL_SETUP  = 3'd1;
    localparam logic [2:0] ST_SEL_SHIFT  = 3'd2;
    localparam logic [2:0] ST_SEL_HOLD   = 3'd3;
    localparam logic [2:0] ST_CONV_SHIFT = 3'd4;
    localparam logic [2:0] ST_CONV_DONE  = 3'd5;

    // Command frame: channel index right-justified, zero padded above, MSB first.
    localparam int CMD_CH_LSB = 0;

    typedef struct packed {
        logic                found;
        logic [MAX_CH_W-1:0] idx;
    } ch_pick_t;

    // Lowest set bit of mask at or above index 'from'.
    function automatic ch_pick_t first_channel(input logic [MAX_CH-1:0] mask,
                                               input logic [MAX_CH_W:0]   from);
        ch_pick_t r;
        r = '0;
        // Descending walk so the last hit is the lowest index.
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                r.found = 1'b1;
                r.idx   = MAX_CH_W'(i);
            end
        end
        return r;
    endfunction

    // Lowest set bit strictly above ch; never wraps back to channel 0.
    function automatic ch_pick_t next_channel(input logic [MAX_CH-1:0]   mask,
                                              input logic [MAX_CH_W-1:0] ch);
        return first_channel(mask, {1'b0, ch} + (MAX_CH_W + 1)'(1));
    endfunction

endpackage

// File: rtl/adc_seq_multich_if.sv
// ---------------------------------------------------------------------------
// adc_seq_multich_if
// Result bus from the scan sequencer to the sample FIFO / readout logic.
//   data_o     DATA_W  conversion result, held until the next valid_o
//   channel_o  CH_W    channel index of data_o
//   valid_o    1       one-clk pulse when data_o/channel_o update
// master: sequencer side, slave: consumer side.
// ---------------------------------------------------------------------------
interface adc_seq_multich_if #(
    parameter int DATA_W = 12,
    parameter int N_CH   = 8,
    parameter int CH_W   = $clog2(N_CH)
) ();
    logic [DATA_W-1:0] data_o;
    logic [CH_W-1:0]   channel_o;
    logic              valid_o;

    modport master (output data_o, output channel_o, output valid_o);
    modport slave  (input  data_o, input  channel_o, input  valid_o);
endinterface

// File: rtl/adc_seq_multich_sclk_gen.sv
// ---------------------------------------------------------------------------
// adc_sclk_gen
// Serial clock generator. Produces SCLK as a plain register (no gated clock).
//   clk, rst_l  system clock, async active-low reset
//   en          divider runs; tick every CLK_DIV clks
//   shift       SCLK may toggle on ticks; when low SCLK is held at 0
//   tick        divider strobe (also used to time 1-tick setup/hold states)
//   rise, fall  strobes coinciding with the clk edge where SCLK goes high/low
//   sclk        serial clock, idle low
// ---------------------------------------------------------------------------
module adc_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_l,
    input  logic en,
    input  logic shift,
    output logic tick,
    output logic rise,
    output logic fall,
    output logic sclk
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;

    assign tick = en && (div_q == DIV_W'(CLK_DIV - 1));
    assign rise = tick && shift && !sclk_q;
    assign fall = tick && shift &&  sclk_q;
    assign sclk = sclk_q;

    always_comb begin
        div_d = '0;
        if (en) div_d = tick ? '0 : div_q + DIV_W'(1);
        sclk_d = 1'b0;
        if (shift) sclk_d = tick ? ~sclk_q : sclk_q;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end
endmodule

// File: rtl/adc_seq_multich.sv
// ---------------------------------------------------------------------------
// adc_seq_multich
// Multi-channel ADC scan sequencer. For each enabled channel it sends a mux
// command frame (channel index, MSB first) and then reads one ADC frame.
// Supports a channel-enable mask, continuous scan and a sticky overrun flag.
// Optional build macro ADC_AVG_EN: 2**AVG_LOG2 conversions per channel,
// averaged (truncating) into a single result.
// Ports:
//   clk, rst_l        system clock, async active-low reset
//   sync              start scan (level, sampled in IDLE)
//   ch_mask[N_CH]     channel enables, latched at scan start
//   cont              restart after last channel (sampled at end of scan)
//   DOUT              ADC serial data in (sampled on SCLK rise)
//   SCLK, CS_ADC,
//   CD_MUX, DIN       serial pins; CD_MUX=1 marks a mux command frame
//   busy              not IDLE
//   overrun           sticky: sync seen while busy; cleared on scan start
//   res (master)      data_o / channel_o / valid_o result bus
// ---------------------------------------------------------------------------
module adc_seq_multich
    import adc_seq_pkg::*;
#(
    parameter int N_CH       = 8,
    parameter int CH_W       = $clog2(N_CH),
    parameter int DATA_W     = 12,
    parameter int FRAME_BITS = 16,
    parameter int CMD_BITS   = 8,
    parameter int CLK_DIV    = 2,
    parameter int AVG_LOG2   = 2
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic            sync,
    input  logic [N_CH-1:0] ch_mask,
    input  logic            cont,
    input  logic            DOUT,
    output logic            SCLK,
    output logic            CS_ADC,
    output logic            CD_MUX,
    output logic            DIN,
    output logic            busy,
    output logic            overrun,
    adc_seq_multich_if.master res
);
    localparam int BITS_MAX = (FRAME_BITS > CMD_BITS) ? FRAME_BITS : CMD_BITS;
    localparam int BC_W     = $clog2(BITS_MAX);

    logic [2:0]          state_q, state_d;
    logic [N_CH-1:0]     mask_q, mask_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [BC_W-1:0]     bit_q, bit_d;
    logic [CMD_BITS-1:0] cmd_q, cmd_d, cmd_new;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CH_W-1:0]     chan_q, chan_d;
    logic                valid_q, valid_d;
    logic                ovr_q, ovr_d;
    logic                din_q, din_d;
    logic                cs_q, cs_d, cd_q, cd_d;
    logic                tick, rise, fall, sclk_en, sclk_shift;
    ch_pick_t            first_pick, next_pick;
    logic                unused_ok;

`ifdef ADC_AVG_EN
    localparam int ACC_W = DATA_W + AVG_LOG2;
    logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
    logic [AVG_LOG2-1:0] conv_q, conv_d;
    assign acc_sum = acc_q + ACC_W'(shift_q);
`endif

    // Divider keeps running through setup/hold so those states last one tick.
    assign sclk_en    = (state_q == ST_SEL_SETUP) || (state_q == ST_SEL_SHIFT) ||
                        (state_q == ST_SEL_HOLD)  || (state_q == ST_CONV_SHIFT);
    assign sclk_shift = (state_q == ST_SEL_SHIFT) || (state_q == ST_CONV_SHIFT);

    adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk   (clk),
        .rst_l (rst_l),
        .en    (sclk_en),
        .shift (sclk_shift),
        .tick  (tick),
        .rise  (rise),
        .fall  (fall),
        .sclk  (SCLK)
    );

    assign first_pick = first_channel(MAX_CH'(ch_mask), '0);
    assign next_pick  = next_channel(MAX_CH'(mask_q), MAX_CH_W'(ch_q));
    assign unused_ok  = ^{first_pick.idx, next_pick.idx} ^ (AVG_LOG2 > 0);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ch_d    = ch_q;
        bit_d   = bit_q;
        cmd_d   = cmd_q;
        shift_d = shift_q;
        din_d   = din_q;
        data_d  = data_q;
        chan_d  = chan_q;
        valid_d = 1'b0;
        ovr_d   = ovr_q;
`ifdef ADC_AVG_EN
        acc_d   = acc_q;
        conv_d  = conv_q;
`endif
        if (sync && (state_q != ST_IDLE)) ovr_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (sync && first_pick.found) begin
                    mask_d  = ch_mask;
                    ch_d    = first_pick.idx[CH_W-1:0];
                    ovr_d   = 1'b0;
                    state_d = ST_SEL_SETUP;
                end
            end
            ST_SEL_SETUP: if (tick) state_d = ST_SEL_SHIFT;
            ST_SEL_SHIFT: begin
                if (fall) begin
                    if (bit_q == BC_W'(CMD_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = ST_SEL_HOLD;
                    end else begin
                        bit_d = bit_q + BC_W'(1);
                        din_d = cmd_q[CMD_BITS-1];
                        cmd_d = cmd_q << 1;
                    end
                end
            end
            ST_SEL_HOLD: if (tick) state_d = ST_CONV_SHIFT;
            ST_CONV_SHIFT: begin
                // Shift keeps only the last DATA_W samples; leading bits fall off.
                if (rise) shift_d = {shift_q[DATA_W-2:0], DOUT};
                if (fall) begin
                    if (bit_q == BC_W'(FRAME_BITS - 1)) begin
                        bit_d = '0;
`ifdef ADC_AVG_EN
                        if (conv_q != '1) begin
                            // Re-enter via hold so CS_ADC drops between frames.
                            acc_d   = acc_sum;
                            conv_d  = conv_q + AVG_LOG2'(1);
                            state_d = ST_SEL_HOLD;
                        end else begin
                            acc_d   = '0;
                            conv_d  = '0;
                            data_d  = acc_sum[ACC_W-1:AVG_LOG2];
                            chan_d  = ch_q;
                            valid_d = 1'b1;
                            state_d = ST_CONV_DONE;
                        end
`else
                        data_d  = shift_q;
                        chan_d  = ch_q;
                        valid_d = 1'b1;
                        state_d = ST_CONV_DONE;
`endif
                    end else begin
                        bit_d = bit_q + BC_W'(1);
                    end
                end
            end
            ST_CONV_DONE: begin
                if (next_pick.found) begin
                    ch_d    = next_pick.idx[CH_W-1:0];
                    state_d = ST_SEL_SETUP;
                end else if (cont && first_pick.found) begin
                    mask_d  = ch_mask;
                    ch_d    = first_pick.idx[CH_W-1:0];
                    state_d = ST_SEL_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Preload the command on entry to setup so DIN carries its MSB there.
        cmd_new = CMD_BITS'(ch_d) << CMD_CH_LSB;
        if ((state_d == ST_SEL_SETUP) && (state_q != ST_SEL_SETUP)) begin
            din_d = cmd_new[CMD_BITS-1];
            cmd_d = cmd_new << 1;
        end
        if (state_d == ST_SEL_HOLD) din_d = 1'b0;
    end

    assign cs_d = (state_d == ST_SEL_SETUP) || (state_d == ST_SEL_SHIFT) ||
                  (state_d == ST_CONV_SHIFT);
    assign cd_d = (state_d == ST_SEL_SETUP) || (state_d == ST_SEL_SHIFT);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            ch_q    <= '0;
            bit_q   <= '0;
            cmd_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            din_q   <= 1'b0;
            cs_q    <= 1'b0;
            cd_q    <= 1'b0;
`ifdef ADC_AVG_EN
            acc_q   <= '0;
            conv_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ch_q    <= ch_d;
            bit_q   <= bit_d;
            cmd_q   <= cmd_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            din_q   <= din_d;
            cs_q    <= cs_d;
            cd_q    <= cd_d;
`ifdef ADC_AVG_EN
            acc_q   <= acc_d;
            conv_q  <= conv_d;
`endif
        end
    end

    assign CS_ADC        = cs_q;
    assign CD_MUX        = cd_q;
    assign DIN           = din_q;
    assign busy          = (state_q != ST_IDLE);
    assign overrun       = ovr_q;
    assign res.data_o    = data_q;
    assign res.channel_o = chan_q;
    assign res.valid_o   = valid_q;
endmodule

// File: tb/tb_adc_seq_multich.sv
module tb_adc_seq_multich;
    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       sync = 1'b0;
    logic       cont = 1'b0;
    logic [7:0] ch_mask = 8'h00;
    logic       DOUT;
    logic       SCLK, CS_ADC, CD_MUX, DIN, busy, overrun;

    adc_seq_multich_if #(.DATA_W(12), .N_CH(8)) res_if ();

    adc_seq_multich #(
        .N_CH(8), .DATA_W(12), .FRAME_BITS(16), .CMD_BITS(8), .CLK_DIV(2), .AVG_LOG2(2)
    ) dut (
        .clk(clk), .rst_l(rst_l), .sync(sync), .ch_mask(ch_mask), .cont(cont),
        .DOUT(DOUT), .SCLK(SCLK), .CS_ADC(CS_ADC), .CD_MUX(CD_MUX), .DIN(DIN),
        .busy(busy), .overrun(overrun), .res(res_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Logs filled by the pin-level models.
    int         vcount = 0;
    int         mcount = 0;
    logic [2:0] vch   [64];
    logic [11:0] vdata [64];
    logic [7:0] mframe[64];
    int         mbits [64];

    // Mux / ADC pin models.
    logic       prev_sclk = 1'b0, prev_cs = 1'b0, prev_cd = 1'b0;
    logic [7:0] mux_sr = 8'h00;
    int         mux_nbits = 0;
    logic [2:0] mux_ch = 3'd0;
    logic [15:0] adc_word = 16'h0000;
    int         adc_idx = 0;
    int         conv_n = 0;
    bit         use_ramp = 1'b0;

    assign DOUT = (adc_idx < 16) ? adc_word[15 - adc_idx] : 1'b0;

    always @(negedge clk) begin
        if (res_if.valid_o) begin
            if (vcount < 64) begin
                vch[vcount]   = res_if.channel_o;
                vdata[vcount] = res_if.data_o;
            end
            vcount++;
        end
        if (CS_ADC && CD_MUX && !(prev_cs && prev_cd)) begin
            mux_sr = 8'h00;
            mux_nbits = 0;
        end
        if (CS_ADC && !CD_MUX && !(prev_cs && !prev_cd)) begin
            adc_idx  = 0;
            adc_word = use_ramp ? 16'(100 + conv_n) : (16'h0ABC | 16'(mux_ch));
            conv_n++;
        end
        if (SCLK && !prev_sclk) begin
            if (CD_MUX) begin
                mux_sr = {mux_sr[6:0], DIN};
                mux_nbits++;
            end else begin
                adc_idx++;
            end
        end
        if (prev_cd && !CD_MUX) begin
            mux_ch = mux_sr[2:0];
            if (mcount < 64) begin
                mframe[mcount] = mux_sr;
                mbits[mcount]  = mux_nbits;
            end
            mcount++;
        end
        prev_sclk = SCLK;
        prev_cs   = CS_ADC;
        prev_cd   = CD_MUX;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        step();
        sync = 1'b0;
    endtask

    task automatic clear_logs();
        vcount = 0;
        mcount = 0;
        conv_n = 0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s_timeout: busy still %0d after %0d clks, required 0", name, busy, budget);
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++;
        if ({SCLK, CS_ADC, CD_MUX, DIN, busy, overrun, res_if.valid_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {SCLK, CS_ADC, CD_MUX, DIN, busy, overrun, res_if.valid_o});
        end
        checks++;
        if ({res_if.data_o, res_if.channel_o} !== 15'h0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h required 0/0", res_if.data_o, res_if.channel_o);
        end
        rst_l = 1'b1;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_full_scan();
        clear_logs();
        ch_mask = 8'hFF;
        cont = 1'b0;
        pulse_sync();
        wait_idle(20000, "full_scan");
        checks++;
        if (vcount !== 8) begin
            errors++;
            $display("FAIL full_count: got %0d valids required 8", vcount);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (vch[i] !== 3'(i) || vdata[i] !== (12'hABC | 12'(i))) begin
                errors++;
                $display("FAIL full_result[%0d]: got ch %0d data %h required ch %0d data %h",
                         i, vch[i], vdata[i], i, 12'hABC | 12'(i));
            end
            checks++;
            if (mframe[i] !== 8'(i) || mbits[i] != 8) begin
                errors++;
                $display("FAIL full_din[%0d]: got frame %h (%0d bits) required %h (8 bits)",
                         i, mframe[i], mbits[i], 8'(i));
            end
        end
    endtask

    task automatic test_sparse_mask();
        logic [2:0]  exp_ch   [3];
        logic [11:0] exp_data [3];
        exp_ch   = '{3'd2, 3'd5, 3'd7};
        exp_data = '{12'hABE, 12'hABD, 12'hABF};
        clear_logs();
        ch_mask = 8'b1010_0100;
        pulse_sync();
        wait_idle(20000, "sparse");
        checks++;
        if (vcount !== 3 || mcount !== 3) begin
            errors++;
            $display("FAIL sparse_count: got %0d valids %0d cmds required 3/3", vcount, mcount);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (vch[i] !== exp_ch[i] || vdata[i] !== exp_data[i]) begin
                errors++;
                $display("FAIL sparse_result[%0d]: got ch %0d data %h required ch %0d data %h",
                         i, vch[i], vdata[i], exp_ch[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_cont();
        logic [2:0] exp_seq [4];
        int n;
        exp_seq = '{3'd0, 3'd7, 3'd0, 3'd7};
        clear_logs();
        ch_mask = 8'h81;
        cont = 1'b1;
        pulse_sync();
        n = 0;
        while (vcount < 3 && n < 20000) begin
            step();
            n++;
        end
        cont = 1'b0;
        checks++;
        if (vcount < 3) begin
            errors++;
            $display("FAIL cont_progress: got %0d valids required 3", vcount);
        end
        wait_idle(20000, "cont");
        checks++;
        if (vcount !== 4) begin
            errors++;
            $display("FAIL cont_count: got %0d valids required 4", vcount);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (vch[i] !== exp_seq[i]) begin
                errors++;
                $display("FAIL cont_seq[%0d]: got ch %0d required %0d", i, vch[i], exp_seq[i]);
            end
        end
    endtask

    task automatic test_overrun();
        int n;
        clear_logs();
        ch_mask = 8'h40;
        pulse_sync();
        n = 0;
        while (!(CS_ADC && !CD_MUX) && n < 2000) begin
            step();
            n++;
        end
        pulse_sync();
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b required 1", overrun);
        end
        wait_idle(20000, "overrun");
        checks++;
        if (vcount !== 1 || vch[0] !== 3'd6 || vdata[0] !== 12'hABE) begin
            errors++;
            $display("FAIL overrun_scan: got %0d valids ch %0d data %h required 1 ch 6 data abe",
                     vcount, vch[0], vdata[0]);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got %b required 1", overrun);
        end
        pulse_sync();
        checks++;
        if (overrun !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL overrun_clear: got ovr %b busy %b required 0/1", overrun, busy);
        end
        wait_idle(20000, "overrun2");
    endtask

    task automatic test_reset_mid();
        int n;
        ch_mask = 8'h0C;
        pulse_sync();
        n = 0;
        while (!(CS_ADC && CD_MUX && SCLK) && n < 2000) begin
            step();
            n++;
        end
        repeat (5) step();
        rst_l = 1'b0;
        #1;
        checks++;
        if ({SCLK, CS_ADC, CD_MUX, DIN, busy, overrun, res_if.valid_o} !== 7'b0) begin
            errors++;
            $display("FAIL midrst_ctrl: got %b required 0000000",
                     {SCLK, CS_ADC, CD_MUX, DIN, busy, overrun, res_if.valid_o});
        end
        checks++;
        if (res_if.data_o !== 12'h000 || res_if.channel_o !== 3'd0) begin
            errors++;
            $display("FAIL midrst_data: got %h/%0d required 000/0", res_if.data_o, res_if.channel_o);
        end
        step();
        rst_l = 1'b1;
        step();
        clear_logs();
        pulse_sync();
        wait_idle(20000, "midrst");
        checks++;
        if (vcount !== 2 || vch[0] !== 3'd2 || vch[1] !== 3'd3 || mframe[0] !== 8'h02) begin
            errors++;
            $display("FAIL midrst_restart: got %0d valids ch %0d,%0d cmd %h required 2 ch 2,3 cmd 02",
                     vcount, vch[0], vch[1], mframe[0]);
        end
    endtask

    task automatic test_zero_mask();
        bit active;
        active = 1'b0;
        clear_logs();
        ch_mask = 8'h00;
        sync = 1'b1;
        repeat (12) begin
            step();
            if (busy || CS_ADC || SCLK) active = 1'b1;
        end
        sync = 1'b0;
        checks++;
        if (active !== 1'b0 || vcount !== 0) begin
            errors++;
            $display("FAIL zero_mask: got activity %b valids %0d required 0/0", active, vcount);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        clear_logs();
        ch_mask = 8'h01;
        sync = 1'b1;
        n = 0;
        step();
        while (!res_if.valid_o && n < 2000) begin
            step();
            n++;
        end
        checks++;
        if (res_if.valid_o !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_valid: got valid %b busy %b required 1/1", res_if.valid_o, busy);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy_drop: got %b required 0", busy);
        end
        step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: got %b required 1", busy);
        end
        sync = 1'b0;
        wait_idle(20000, "b2b");
        checks++;
        if (vcount !== 2 || vch[1] !== 3'd0) begin
            errors++;
            $display("FAIL b2b_count: got %0d valids ch %0d required 2 ch 0", vcount, vch[1]);
        end
    endtask

`ifdef ADC_AVG_EN
    task automatic test_avg();
        clear_logs();
        use_ramp = 1'b1;
        ch_mask = 8'h01;
        pulse_sync();
        wait_idle(20000, "avg");
        use_ramp = 1'b0;
        checks++;
        if (vcount !== 1 || vch[0] !== 3'd0 || vdata[0] !== 12'd101) begin
            errors++;
            $display("FAIL avg_result: got %0d valids ch %0d data %0d required 1 ch 0 data 101",
                     vcount, vch[0], vdata[0]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_scan();
        test_sparse_mask();
        test_cont();
        test_overrun();
        test_reset_mid();
        test_zero_mask();
        test_back_to_back();
`ifdef ADC_AVG_EN
        test_avg();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
